// File: rtl/control_unit.sv
// Multi-cycle Moore control sequencer: fetch (T0-T2), opcode-specific execute (T3-T7), then fetch or halt.
// Latency: one step per clock; strobes are combinational from the current state and IR[31:27].
// Backpressure: none; Stop is honoured only on the last step of an instruction, and only clr leaves HALT.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        branch_flag,
    input  logic        Stop,
    output logic        PCout,
    output logic        ZHighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  operation,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state;
    logic       br_taken;
    logic [4:0] opcode;
    state_t     last;

    // Only the opcode field steers the sequencer; operand fields belong to the datapath.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];
    assign opcode    = IR[31:27];

    logic is_alu, is_imm, is_muldiv, is_unary, is_ldst;
    assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_muldiv = (opcode == OP_DIV) || (opcode == OP_MUL);
    assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_ldst   = (opcode <= OP_ST);

    // Final execute step of the current instruction; nop and undefined opcodes end at T3.
    always_comb begin
        last = S_T3;
        if (is_alu || is_imm || opcode == OP_LDI) last = S_T5;
        else if (is_muldiv || opcode == OP_BR)    last = S_T6;
        else if (is_unary)                        last = S_T4;
        else if (is_ldst)                         last = S_T7;
    end

    // State register plus branch decision captured as the branch step T5 ends.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_RST;
            br_taken <= 1'b0;
        end else begin
            if (state == S_T5 && opcode == OP_BR) br_taken <= branch_flag;
            case (state)
                S_RST:   state <= S_T0;
                S_HALT:  state <= S_HALT;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                default: begin
                    if (state == S_T3 && opcode == OP_HALT) state <= S_HALT;
                    else if (state == last)                 state <= Stop ? S_HALT : S_T0;
                    else                                    state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    // Moore decode of every datapath strobe from state and opcode; unlisted strobes stay 0.
    always_comb begin
        {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin}         = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout}             = '0;
        operation = 5'b00000;
        Run       = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_unary) begin
                    Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode;
                end
                else if (is_ldst) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                else if (opcode == OP_BR) begin Gra = 1'b1; Rout = 1'b1; end
                else if (opcode == OP_JR) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                else if (opcode == OP_IN) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (opcode == OP_MFHI) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (opcode == OP_MFLO) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                if (is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode;
                end else if (is_imm) begin
                    Cout = 1'b1; ZLOin = 1'b1;
                    operation = (opcode == OP_ADDI) ? OP_ADD :
                                (opcode == OP_ANDI) ? OP_AND : OP_OR;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1; operation = opcode;
                end else if (is_unary) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ldst) begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD;
                end else if (opcode == OP_BR) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || opcode == OP_LDI) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (is_ldst) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (opcode == OP_BR) begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                end else if (opcode == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (opcode == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (opcode == OP_BR && br_taken) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (opcode == OP_ST) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks fetch and execute sequences step by step.
// Each step compares the full strobe vector against hand-built expected masks.
// Also checks bus-source exclusivity at every step.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        branch_flag = 1'b0;
    logic        Stop = 1'b0;
    logic PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
    logic [4:0] operation;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .branch_flag(branch_flag), .Stop(Stop),
        .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .operation(operation), .Run(Run)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] PCO = 32'h1 << 31, ZHO = 32'h1 << 30, ZLO = 32'h1 << 29;
    localparam logic [31:0] HIO = 32'h1 << 28, LOO = 32'h1 << 27, INP = 32'h1 << 26;
    localparam logic [31:0] CO  = 32'h1 << 25, MDO = 32'h1 << 24, MAI = 32'h1 << 23;
    localparam logic [31:0] PCI = 32'h1 << 22, MDI = 32'h1 << 21, IRI = 32'h1 << 20;
    localparam logic [31:0] YI  = 32'h1 << 19, HII = 32'h1 << 18, LOI = 32'h1 << 17;
    localparam logic [31:0] ZHI = 32'h1 << 16, ZLI = 32'h1 << 15, INC = 32'h1 << 14;
    localparam logic [31:0] RD  = 32'h1 << 13, WR  = 32'h1 << 12, GA  = 32'h1 << 11;
    localparam logic [31:0] GB  = 32'h1 << 10, GC  = 32'h1 << 9,  RI  = 32'h1 << 8;
    localparam logic [31:0] RO  = 32'h1 << 7,  BA  = 32'h1 << 6,  RUN = 32'h1;
    localparam logic [31:0] ZERO = 32'h0;

    localparam logic [31:0] E_T0 = PCO | MAI | INC | ZLI | RUN;
    localparam logic [31:0] E_T1 = ZLO | PCI | RD | MDI | RUN;
    localparam logic [31:0] E_T2 = MDO | IRI | RUN;

    function automatic logic [31:0] opf(input logic [4:0] op);
        return {26'b0, op, 1'b0};
    endfunction

    logic [31:0] obs;
    assign obs = {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout,
                  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin,
                  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, operation, Run};

    logic [9:0] bus;
    assign bus = {PCout, ZHighout, Zlowout, HIout, LOout, InPortout, Cout, MDRout, Rout, BAout};

    task automatic chk(input string tag, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert ($countones(bus) <= 1) else begin
            errors++;
            $error("FAIL %s_busexcl observed=%b expected=at most one", tag, bus);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #2;
        chk(tag, exp);
    endtask

    task automatic fetch12;
        step("t1", E_T1);
        step("t2", E_T2);
    endtask

    initial begin
        // Reset held for two edges, then release into T0.
        step("rst_a", ZERO);
        step("rst_b", ZERO);
        clr = 1'b0;
        step("rst_t0", E_T0);

        // add: 6 cycles, 7th is T0.
        IR = 32'h1800_0000;
        fetch12;
        step("add_t3", GB | RO | YI | RUN);
        step("add_t4", GC | RO | ZLI | opf(5'b00011) | RUN);
        step("add_t5", ZLO | GA | RI | RUN);
        step("add_t0", E_T0);

        // ld: 8 cycles.
        IR = 32'h0000_0000;
        fetch12;
        step("ld_t3", GB | BA | YI | RUN);
        step("ld_t4", CO | ZLI | opf(5'b00011) | RUN);
        step("ld_t5", ZLO | MAI | RUN);
        step("ld_t6", RD | MDI | RUN);
        step("ld_t7", MDO | GA | RI | RUN);
        step("ld_t0", E_T0);

        // st: 8 cycles.
        IR = 32'h1000_0000;
        fetch12;
        step("st_t3", GB | BA | YI | RUN);
        step("st_t4", CO | ZLI | opf(5'b00011) | RUN);
        step("st_t5", ZLO | MAI | RUN);
        step("st_t6", GA | RO | MDI | RUN);
        step("st_t7", WR | RUN);
        step("st_t0", E_T0);

        // Branch taken.
        IR = 32'h9800_0000;
        fetch12;
        step("brt_t3", GA | RO | RUN);
        step("brt_t4", PCO | YI | RUN);
        step("brt_t5", CO | ZLI | opf(5'b00011) | RUN);
        branch_flag = 1'b1;
        step("brt_t6", ZLO | PCI | RUN);
        branch_flag = 1'b0;
        step("brt_t0", E_T0);

        // Branch not taken.
        fetch12;
        step("brn_t3", GA | RO | RUN);
        step("brn_t4", PCO | YI | RUN);
        step("brn_t5", CO | ZLI | opf(5'b00011) | RUN);
        step("brn_t6", RUN);
        step("brn_t0", E_T0);

        // ori uses the OR ALU code with the constant operand.
        IR = 32'h7000_0000;
        fetch12;
        step("ori_t3", GB | RO | YI | RUN);
        step("ori_t4", CO | ZLI | opf(5'b00110) | RUN);
        step("ori_t5", ZLO | GA | RI | RUN);
        step("ori_t0", E_T0);

        // neg: 5 cycles.
        IR = 32'h8800_0000;
        fetch12;
        step("neg_t3", GB | RO | ZLI | opf(5'b10001) | RUN);
        step("neg_t4", ZLO | GA | RI | RUN);
        step("neg_t0", E_T0);

        // jr: 4 cycles.
        IR = 32'hA000_0000;
        fetch12;
        step("jr_t3", GA | RO | PCI | RUN);
        step("jr_t0", E_T0);

        // mul: 7 cycles.
        IR = 32'h8000_0000;
        fetch12;
        step("mul_t3", GA | RO | YI | RUN);
        step("mul_t4", GB | RO | ZHI | ZLI | opf(5'b10000) | RUN);
        step("mul_t5", ZLO | LOI | RUN);
        step("mul_t6", ZHO | HII | RUN);
        step("mul_t0", E_T0);

        // halt: parks in HALT until clr.
        IR = 32'hD800_0000;
        fetch12;
        step("halt_t3", RUN);
        for (int i = 0; i < 20; i++) step("halt_hold", ZERO);
        clr = 1'b1;
        step("halt_rst", ZERO);
        clr = 1'b0;
        step("halt_t0", E_T0);

        // Stop on the last step of add goes to HALT instead of T0.
        IR = 32'h1800_0000;
        fetch12;
        step("stop_t3", GB | RO | YI | RUN);
        step("stop_t4", GC | RO | ZLI | opf(5'b00011) | RUN);
        step("stop_t5", ZLO | GA | RI | RUN);
        Stop = 1'b1;
        step("stop_halt", ZERO);
        Stop = 1'b0;
        step("stop_hold", ZERO);
        clr = 1'b1;
        step("stop_rst", ZERO);
        clr = 1'b0;
        step("stop_t0", E_T0);

        // clr during ld T6 aborts the instruction.
        IR = 32'h0000_0000;
        fetch12;
        step("abort_t3", GB | BA | YI | RUN);
        step("abort_t4", CO | ZLI | opf(5'b00011) | RUN);
        step("abort_t5", ZLO | MAI | RUN);
        step("abort_t6", RD | MDI | RUN);
        clr = 1'b1;
        step("abort_rst", ZERO);
        clr = 1'b0;
        step("abort_t0", E_T0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
